dcim_bitserial_driver: RTL and testbench

DCIM_BITSERIAL_DRIVER -- requirements
Module: dcim_bitserial_driver

---
 rtl/dcim_drv_pkg.sv | 23 ++
 rtl/dcim_bitplane_shifter.sv | 50 +++++
 rtl/dcim_bitserial_driver.sv | 174 +++++++++++++++++
 tb/tb_dcim_bitserial_driver.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dcim_drv_pkg.sv
// dcim_drv_pkg
//   Shared definitions for the DCIM bit-serial activation driver:
//   FSM state encoding, default geometry constants and an index-width helper.
package dcim_drv_pkg;

  localparam int unsigned DEF_N_ROWS  = 16;
  localparam int unsigned DEF_IN_BITS = 8;
  localparam int unsigned DEF_ACC_W   = 51;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SHIFT,
    ST_CAPTURE,
    ST_HOLD
  } drv_state_t;

  // Width of a bit index into an n-bit word (at least one bit).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dcim_bitplane_shifter.sv
// dcim_bitplane_shifter
//   Holds one loaded activation vector (N_ROWS lanes of IN_BITS each) and
//   presents the bit plane selected by i_k: bit r of o_plane is lane r bit k.
//   The plane is forced to zero while i_en is low.
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset (clears vector)
//   i_load     load i_data into the vector register
//   i_data     N_ROWS*IN_BITS packed lanes, lane r at [r*IN_BITS +: IN_BITS]
//   i_en       plane output enable
//   i_k        bit index to present
//   o_plane    selected bit plane
module dcim_bitplane_shifter
  import dcim_drv_pkg::*;
#(
  parameter int unsigned N_ROWS  = DEF_N_ROWS,
  parameter int unsigned IN_BITS = DEF_IN_BITS,
  parameter int unsigned KW      = idx_w(IN_BITS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_load,
  input  logic [N_ROWS*IN_BITS-1:0]   i_data,
  input  logic                        i_en,
  input  logic [KW-1:0]               i_k,
  output logic [N_ROWS-1:0]           o_plane
);

  logic [N_ROWS*IN_BITS-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end
  end

  always_comb begin
    logic [IN_BITS-1:0] v_lane;
    v_lane  = '0;
    o_plane = '0;
    if (i_en) begin
      for (int unsigned r = 0; r < N_ROWS; r++) begin
        v_lane     = r_data[r*IN_BITS +: IN_BITS];
        o_plane[r] = v_lane[i_k];
      end
    end
  end

endmodule

// File: rtl/dcim_bitserial_driver.sv
// dcim_bitserial_driver
//   Feeds an activation vector to a digital CIM macro one bit plane per cycle,
//   MSB first, drives the accumulator clear/enable strobes and captures the
//   accumulated result for a valid/ready output handshake.
//   Sequence: IDLE -> CLEAR (1 cycle) -> SHIFT (IN_BITS cycles) -> CAPTURE -> HOLD.
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     activation vector handshake, in_data lane r at [r*IN_BITS +: IN_BITS]
//   bit_out               current bit plane (zero outside SHIFT)
//   acm_en, st            accumulator enable and clear strobe
//   res_in                registered accumulator output
//   out_valid/out_ready   result handshake, out_data holds the captured result
//   busy                  high whenever the FSM is not in IDLE
// Configuration:
//   DCIM_DRV_PREFETCH_EN  adds a one-entry input prefetch buffer so the next
//                         vector can be accepted while the current one runs.
module dcim_bitserial_driver
  import dcim_drv_pkg::*;
#(
  parameter int unsigned N_ROWS  = DEF_N_ROWS,
  parameter int unsigned IN_BITS = DEF_IN_BITS,
  parameter int unsigned ACC_W   = DEF_ACC_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N_ROWS*IN_BITS-1:0]   in_data,
  output logic [N_ROWS-1:0]           bit_out,
  output logic                        acm_en,
  output logic                        st,
  input  logic [ACC_W-1:0]            res_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ACC_W-1:0]            out_data,
  output logic                        busy
);

  localparam int unsigned     KW    = idx_w(IN_BITS);
  localparam logic [KW-1:0]   K_TOP = KW'(IN_BITS - 1);
  localparam logic [KW-1:0]   K_ONE = KW'(1);

  drv_state_t                 r_state;
  logic [KW-1:0]              r_k;
  logic                       r_acm_en;
  logic                       r_st;
  logic                       r_busy;
  logic                       r_out_valid;
  logic [ACC_W-1:0]           r_out_data;

  logic                       w_accept;
  logic                       w_out_fire;
  logic                       w_load;
  logic [N_ROWS*IN_BITS-1:0]  w_load_data;

  assign w_accept   = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;

`ifdef DCIM_DRV_PREFETCH_EN
  logic                       r_buf_full;
  logic [N_ROWS*IN_BITS-1:0]  r_buf_data;
  logic                       w_bypass;
  logic                       w_pop;

  assign in_ready = !rst && !r_buf_full;

  // A vector goes straight to the shifter when the FSM can start on it this
  // edge: in IDLE, or when leaving HOLD with nothing buffered. Otherwise it
  // waits in the buffer, which has priority when HOLD completes.
  assign w_bypass    = w_accept && ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && w_out_fire));
  assign w_pop       = (r_state == ST_HOLD) && w_out_fire && r_buf_full;
  assign w_load      = w_bypass || w_pop;
  assign w_load_data = w_pop ? r_buf_data : in_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf_full <= 1'b0;
      r_buf_data <= '0;
    end else if (w_accept && !w_bypass) begin
      r_buf_full <= 1'b1;
      r_buf_data <= in_data;
    end else if (w_pop) begin
      r_buf_full <= 1'b0;
    end
  end
`else
  assign in_ready    = !rst && (r_state == ST_IDLE);
  assign w_load      = (r_state == ST_IDLE) && w_accept;
  assign w_load_data = in_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_k         <= K_TOP;
      r_acm_en    <= 1'b0;
      r_st        <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_state  <= ST_CLEAR;
            r_busy   <= 1'b1;
            r_st     <= 1'b1;
            r_acm_en <= 1'b1;
          end
        end
        ST_CLEAR: begin
          r_state <= ST_SHIFT;
          r_st    <= 1'b0;
          r_k     <= K_TOP;
        end
        ST_SHIFT: begin
          if (r_k == '0) begin
            r_state  <= ST_CAPTURE;
            r_acm_en <= 1'b0;
            r_k      <= K_TOP;
          end else begin
            r_k <= r_k - K_ONE;
          end
        end
        ST_CAPTURE: begin
          r_state     <= ST_HOLD;
          r_out_data  <= res_in;
          r_out_valid <= 1'b1;
        end
        ST_HOLD: begin
          if (w_out_fire) begin
            r_out_valid <= 1'b0;
            if (w_load) begin
              r_state  <= ST_CLEAR;
              r_st     <= 1'b1;
              r_acm_en <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_acm_en    <= 1'b0;
          r_st        <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  dcim_bitplane_shifter #(
    .N_ROWS  (N_ROWS),
    .IN_BITS (IN_BITS),
    .KW      (KW)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_data  (w_load_data),
    .i_en    (r_state == ST_SHIFT),
    .i_k     (r_k),
    .o_plane (bit_out)
  );

  assign acm_en    = r_acm_en;
  assign st        = r_st;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_dcim_bitserial_driver.sv
// tb_dcim_bitserial_driver
//   Directed bench for dcim_bitserial_driver with N_ROWS=16, IN_BITS=4.
//   A behavioural accumulator drives res_in; the expected result of a vector
//   is the plain sum of its lane values.
module tb_dcim_bitserial_driver;

  localparam int unsigned NR = 16;
  localparam int unsigned IB = 4;
  localparam int unsigned AW = 20;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [NR*IB-1:0]   in_data;
  logic [NR-1:0]      bit_out;
  logic               acm_en;
  logic               st;
  logic [AW-1:0]      res_in;
  logic               out_valid;
  logic               out_ready;
  logic [AW-1:0]      out_data;
  logic               busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dcim_bitserial_driver #(
    .N_ROWS  (NR),
    .IN_BITS (IB),
    .ACC_W   (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .bit_out   (bit_out),
    .acm_en    (acm_en),
    .st        (st),
    .res_in    (res_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // Accumulator model: nout <= (nout<<1) + popcount(plane), cleared by st.
  logic [AW-1:0] acc;
  assign res_in = acc;

  function automatic logic [AW-1:0] popc(input logic [NR-1:0] v);
    logic [AW-1:0] c;
    c = '0;
    for (int i = 0; i < NR; i++) c = c + AW'(v[i]);
    return c;
  endfunction

  always @(posedge clk) begin
    if (rst || st) acc <= '0;
    else if (acm_en) acc <= (acc << 1) + popc(bit_out);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [NR*IB-1:0] v);
    in_data  = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick(); tick();
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_data !== '0) begin n_errors++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
    n_checks++; if (bit_out !== '0) begin n_errors++; $display("FAIL reset_bit_out: got %h expected 0", bit_out); end
    n_checks++; if ({acm_en, st, busy} !== 3'b000) begin n_errors++; $display("FAIL reset_strobes: got %b expected 000", {acm_en, st, busy}); end
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
  endtask

  // Lanes 0xA / 0x3: planes 01, 00, 11, 10 and result 13 at the 6th edge.
  task automatic test_basic;
    logic [NR-1:0] planes [4];
    planes[0] = 16'h0001; planes[1] = 16'h0000; planes[2] = 16'h0003; planes[3] = 16'h0002;
    out_ready = 1'b1;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL basic_in_ready_idle: got %b expected 1", in_ready); end
    send(64'h3A);
    n_checks++; if ({st, acm_en, busy, bit_out} !== {3'b111, 16'h0000}) begin n_errors++; $display("FAIL basic_clear: got st/acm/busy=%b bit_out=%h expected 111/0000", {st, acm_en, busy}, bit_out); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if ({st, acm_en, bit_out} !== {2'b01, planes[i]}) begin n_errors++; $display("FAIL basic_plane%0d: got st/acm=%b bit_out=%h expected 01/%h", i, {st, acm_en}, bit_out, planes[i]); end
    end
    tick();
    n_checks++; if ({acm_en, out_valid, bit_out} !== {2'b00, 16'h0000}) begin n_errors++; $display("FAIL basic_capture: got acm/ov=%b bit_out=%h expected 00/0000", {acm_en, out_valid}, bit_out); end
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL basic_latency: got out_valid=%b at edge 6 expected 1", out_valid); end
    n_checks++; if (out_data !== 20'd13) begin n_errors++; $display("FAIL basic_result: got %0d expected 13", out_data); end
    tick();
    n_checks++; if ({out_valid, busy, in_ready} !== 3'b001) begin n_errors++; $display("FAIL basic_return_idle: got ov/busy/rdy=%b expected 001", {out_valid, busy, in_ready}); end
  endtask

  task automatic test_all_ones;
    out_ready = 1'b1;
    send(64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 20 && out_valid !== 1'b1; i++) tick();
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL all_ones_timeout: got out_valid=%b expected 1", out_valid); end
    n_checks++; if (out_data !== 20'd240) begin n_errors++; $display("FAIL all_ones_result: got %0d expected 240", out_data); end
    tick();
  endtask

  // Lanes 0x9/0x6/0xF -> 30, held for 10 stalled cycles before release.
  task automatic test_stall;
    logic exp_rdy;
`ifdef DCIM_DRV_PREFETCH_EN
    exp_rdy = 1'b1;
`else
    exp_rdy = 1'b0;
`endif
    out_ready = 1'b0;
    send(64'hF69);
    for (int i = 0; i < 20 && out_valid !== 1'b1; i++) tick();
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL stall_timeout: got out_valid=%b expected 1", out_valid); end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++; if ({out_valid, out_data} !== {1'b1, 20'd30}) begin n_errors++; $display("FAIL stall_hold%0d: got ov=%b data=%0d expected 1/30", i, out_valid, out_data); end
      n_checks++; if ({in_ready, busy} !== {exp_rdy, 1'b1}) begin n_errors++; $display("FAIL stall_ready%0d: got rdy/busy=%b expected %b1", i, {in_ready, busy}, exp_rdy); end
    end
    out_ready = 1'b1;
    tick();
    n_checks++; if ({out_valid, busy, out_data} !== {2'b00, 20'd30}) begin n_errors++; $display("FAIL stall_release: got ov/busy=%b data=%0d expected 00/30", {out_valid, busy}, out_data); end
  endtask

  task automatic test_reset_mid_shift;
    out_ready = 1'b1;
    send(64'h87);
    tick();
    tick();
    n_checks++; if (bit_out !== 16'h0001) begin n_errors++; $display("FAIL midrst_plane: got %h expected 0001", bit_out); end
    rst = 1'b1;
    tick();
    n_checks++; if ({out_valid, acm_en, st, busy, in_ready} !== 5'b00000) begin n_errors++; $display("FAIL midrst_ctrl: got ov/acm/st/busy/rdy=%b expected 00000", {out_valid, acm_en, st, busy, in_ready}); end
    n_checks++; if ({bit_out, out_data} !== '0) begin n_errors++; $display("FAIL midrst_data: got bit_out=%h out_data=%0d expected 0/0", bit_out, out_data); end
    rst = 1'b0;
    #1;
    send(64'h55);
    for (int i = 0; i < 20 && out_valid !== 1'b1; i++) tick();
    n_checks++; if ({out_valid, out_data} !== {1'b1, 20'd10}) begin n_errors++; $display("FAIL midrst_next: got ov=%b data=%0d expected 1/10", out_valid, out_data); end
    tick();
  endtask

  // Lanes 0x1/0xC/0x7 -> 20 while in_data (and in_valid without prefetch) churn.
  task automatic test_hold_data;
    out_ready = 1'b1;
    send(64'h7C1);
    for (int i = 0; i < 5; i++) begin
      in_data = {$urandom, $urandom};
`ifndef DCIM_DRV_PREFETCH_EN
      in_valid = ~in_valid;
`endif
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 20 && out_valid !== 1'b1; i++) tick();
    n_checks++; if ({out_valid, out_data} !== {1'b1, 20'd20}) begin n_errors++; $display("FAIL hold_data_result: got ov=%b data=%0d expected 1/20", out_valid, out_data); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL hold_data_idle: got busy=%b expected 0", busy); end
  endtask

  // Second vector (lanes 0x5/0x5/0x1 -> 11) offered during the first run.
  task automatic test_back_to_back;
    out_ready = 1'b1;
    send(64'h3A);
    tick();
    in_data  = 64'h155;
    in_valid = 1'b1;
`ifdef DCIM_DRV_PREFETCH_EN
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready_shift: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    in_data  = 64'hDEAD_BEEF_0BAD_F00D;
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL b2b_buffer_full: got in_ready=%b expected 0", in_ready); end
    for (int i = 0; i < 20 && out_valid !== 1'b1; i++) tick();
    n_checks++; if ({out_valid, out_data} !== {1'b1, 20'd13}) begin n_errors++; $display("FAIL b2b_first: got ov=%b data=%0d expected 1/13", out_valid, out_data); end
    tick();
    n_checks++; if ({st, busy, out_valid} !== 3'b110) begin n_errors++; $display("FAIL b2b_direct_clear: got st/busy/ov=%b expected 110", {st, busy, out_valid}); end
    for (int i = 0; i < 20 && out_valid !== 1'b1; i++) tick();
    n_checks++; if ({out_valid, out_data} !== {1'b1, 20'd11}) begin n_errors++; $display("FAIL b2b_second: got ov=%b data=%0d expected 1/11", out_valid, out_data); end
    tick();
    n_checks++; if ({busy, in_ready} !== 2'b01) begin n_errors++; $display("FAIL b2b_idle: got busy/rdy=%b expected 01", {busy, in_ready}); end
`else
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL b2b_ready_shift: got %b expected 0", in_ready); end
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20 && out_valid !== 1'b1; i++) tick();
    n_checks++; if ({out_valid, out_data} !== {1'b1, 20'd13}) begin n_errors++; $display("FAIL b2b_first: got ov=%b data=%0d expected 1/13", out_valid, out_data); end
    tick();
    n_checks++; if ({busy, st, in_ready} !== 3'b001) begin n_errors++; $display("FAIL b2b_no_second: got busy/st/rdy=%b expected 001", {busy, st, in_ready}); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_ones();
    test_stall();
    test_reset_mid_shift();
    test_hold_data();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

endmodule
